// File: rtl/bp_decision_unit_pkg.sv
// Shared fixed-point definitions and FSM state encoding for the BP hard-decision unit.
// Default LLR format: 20-bit two's complement, 1 sign / 7 integer / 12 fractional bits.
package bp_decision_unit_pkg;

    localparam int W_DEF = 20;
    localparam int FRAC  = 12;

    localparam logic [W_DEF-1:0] LLR_MAX = 20'h7FFFF;
    localparam logic [W_DEF-1:0] LLR_MIN = 20'h80000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CHECK   = 2'd2,
        ST_OUTPUT  = 2'd3
    } state_t;

    function automatic logic [W_DEF-1:0] llr_from_int(input int v);
        return W_DEF'(v <<< FRAC);
    endfunction

    function automatic logic llr_is_rail(input logic [W_DEF-1:0] x);
        return (x == LLR_MAX) || (x == LLR_MIN);
    endfunction

endpackage

// File: rtl/bp_decision_unit_sat_add.sv
// Combinational saturating W-bit adder; neg is the sign of the clamped sum.
module bp_decision_unit_sat_add #(
    parameter int W = 20
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         neg
);

    logic signed [W:0] wide;

    // Overflow iff the two top bits of the W+1-bit sum disagree; the top bit gives the rail.
    function automatic logic [W-1:0] sat_w(input logic signed [W:0] s);
        if (s[W] != s[W-1]) begin
            return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
        return s[W-1:0];
    endfunction

    always_comb begin
        wide = $signed({a[W-1], a}) + $signed({b[W-1], b});
        sum  = sat_w(wide);
        neg  = sum[W-1];
    end

endmodule

// File: rtl/bp_decision_unit.sv
// BP hard-decision and early-termination stage: slices L+R per node, stops on convergence or MAX_ITER.
// Optional soft output port out_llr is enabled by defining BP_DEC_SOFT_OUT_EN.
module bp_decision_unit
    import bp_decision_unit_pkg::*;
#(
    parameter int N            = 64,
    parameter int W            = W_DEF,
    parameter int MAX_ITER     = 40,
    parameter int STABLE_ITERS = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   frozen_mask,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_l,
    input  logic [W-1:0]   in_r,
    input  logic           in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_bits,
    output logic [6:0]     out_iters,
    output logic           out_early,
    output logic           proto_err
`ifdef BP_DEC_SOFT_OUT_EN
    ,
    output logic [N*W-1:0] out_llr
`endif
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [6:0]     iter_q, iter_d;
    logic [6:0]     stable_q, stable_d;
    logic           seen_q, seen_d;
    logic [N-1:0]   mask_q, mask_d;
    logic [N-1:0]   cur_q, cur_d;
    logic [N-1:0]   prev_q, prev_d;
    logic [N-1:0]   bits_q, bits_d;
    logic [6:0]     iters_q, iters_d;
    logic           early_q, early_d;
`ifdef BP_DEC_SOFT_OUT_EN
    logic [N*W-1:0] cur_llr_q, cur_llr_d;
    logic [N*W-1:0] llr_q, llr_d;
`endif

    logic [W-1:0]   sum;
    logic           sum_neg;
    logic           acc;
    logic           idx_end;

    bp_decision_unit_sat_add #(.W(W)) u_sat_add (
        .a   (in_l),
        .b   (in_r),
        .sum (sum),
        .neg (sum_neg)
    );

    // A start in the same cycle wins over any beat, so the port is closed for it.
    assign in_ready  = (state_q == ST_COLLECT) && !start;
    assign acc       = in_valid && in_ready;
    assign idx_end   = (idx_q == IW'(N - 1));
    assign proto_err = acc && (in_last != idx_end);
    assign out_valid = (state_q == ST_OUTPUT);
    assign out_bits  = bits_q;
    assign out_iters = iters_q;
    assign out_early = early_q;
`ifdef BP_DEC_SOFT_OUT_EN
    assign out_llr   = llr_q;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        iter_d    = iter_q;
        stable_d  = stable_q;
        seen_d    = seen_q;
        mask_d    = mask_q;
        cur_d     = cur_q;
        prev_d    = prev_q;
        bits_d    = bits_q;
        iters_d   = iters_q;
        early_d   = early_q;
`ifdef BP_DEC_SOFT_OUT_EN
        cur_llr_d = cur_llr_q;
        llr_d     = llr_q;
`endif
        if (start) begin
            mask_d   = frozen_mask;
            idx_d    = '0;
            iter_d   = '0;
            stable_d = '0;
            seen_d   = 1'b0;
            state_d  = ST_COLLECT;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    // in_last is only checked; the node counter alone closes the iteration.
                    if (acc) begin
                        cur_d[idx_q] = sum_neg && !mask_q[idx_q];
`ifdef BP_DEC_SOFT_OUT_EN
                        cur_llr_d[idx_q*W +: W] = sum;
`endif
                        idx_d = idx_q + IW'(1);
                        if (idx_end) begin
                            state_d = ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    iter_d = iter_q + 7'd1;
                    if (!seen_q) begin
                        stable_d = '0;
                    end else if (cur_q == prev_q) begin
                        stable_d = stable_q + 7'd1;
                    end else begin
                        stable_d = '0;
                    end
                    prev_d = cur_q;
                    seen_d = 1'b1;
                    if ((stable_d == 7'(STABLE_ITERS)) || (iter_d == 7'(MAX_ITER))) begin
                        bits_d  = cur_q;
                        iters_d = iter_d;
                        early_d = (stable_d == 7'(STABLE_ITERS));
`ifdef BP_DEC_SOFT_OUT_EN
                        llr_d   = cur_llr_q;
`endif
                        state_d = ST_OUTPUT;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            iter_q    <= '0;
            stable_q  <= '0;
            seen_q    <= 1'b0;
            mask_q    <= '0;
            cur_q     <= '0;
            prev_q    <= '0;
            bits_q    <= '0;
            iters_q   <= '0;
            early_q   <= 1'b0;
`ifdef BP_DEC_SOFT_OUT_EN
            cur_llr_q <= '0;
            llr_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            iter_q    <= iter_d;
            stable_q  <= stable_d;
            seen_q    <= seen_d;
            mask_q    <= mask_d;
            cur_q     <= cur_d;
            prev_q    <= prev_d;
            bits_q    <= bits_d;
            iters_q   <= iters_d;
            early_q   <= early_d;
`ifdef BP_DEC_SOFT_OUT_EN
            cur_llr_q <= cur_llr_d;
            llr_q     <= llr_d;
`endif
        end
    end

endmodule

// File: tb/tb_bp_decision_unit.sv
// Directed bench for bp_decision_unit with N=8, MAX_ITER=5, STABLE_ITERS=2 (1.0 = 20'h01000).
module tb_bp_decision_unit;

    localparam int N = 8;
    localparam int W = 20;

    localparam logic [W-1:0] P1   = 20'h01000;
    localparam logic [W-1:0] P3   = 20'h03000;
    localparam logic [W-1:0] M3   = 20'hFD000;
    localparam logic [W-1:0] BIGP = 20'h7F000;
    localparam logic [W-1:0] BIGN = 20'h80000;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [N-1:0]   frozen_mask = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_l = '0;
    logic [W-1:0]   in_r = '0;
    logic           in_last = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [N-1:0]   out_bits;
    logic [6:0]     out_iters;
    logic           out_early;
    logic           proto_err;
`ifdef BP_DEC_SOFT_OUT_EN
    logic [N*W-1:0] out_llr;
`endif

    int checks = 0;
    int failures = 0;
    int perr_cnt = 0;

    bp_decision_unit #(
        .N(N), .W(W), .MAX_ITER(5), .STABLE_ITERS(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .frozen_mask (frozen_mask),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_l        (in_l),
        .in_r        (in_r),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bits    (out_bits),
        .out_iters   (out_iters),
        .out_early   (out_early),
        .proto_err   (proto_err)
`ifdef BP_DEC_SOFT_OUT_EN
        ,
        .out_llr     (out_llr)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (proto_err === 1'b1) perr_cnt <= perr_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_node(input logic [W-1:0] l, input logic [W-1:0] r, input logic last);
        int t;
        @(negedge clk);
        in_l = l;
        in_r = r;
        in_last = last;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("in_ready_wait", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    // Node i gets L=+1.0 and R=-3.0 when negs[i] is set (sum -2.0), else R=+3.0 (sum +4.0).
    task automatic send_iter(input logic [N-1:0] negs, input int extra_last);
        for (int i = 0; i < N; i++) begin
            send_node(P1, negs[i] ? M3 : P3, (i == N - 1) || (i == extra_last));
        end
    endtask

    task automatic do_start(input logic [N-1:0] m);
        @(negedge clk);
        start = 1'b1;
        frozen_mask = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called right after the last node of the stopping iteration: CHECK cycle, then OUTPUT.
    task automatic expect_done(input string tag, input logic [N-1:0] bits, input int iters, input logic early);
        @(negedge clk);
        check({tag, "_valid_in_check"}, {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_bits"}, {56'd0, out_bits}, {56'd0, bits});
        check({tag, "_iters"}, {57'd0, out_iters}, 64'(iters));
        check({tag, "_early"}, {63'd0, out_early}, {63'd0, early});
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_consumed"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        logic [N-1:0] snap_bits;
        logic [6:0]   snap_iters;
        logic         snap_early;
        logic         hold_ok;
        int           p0;

        repeat (3) @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_proto_err", {63'd0, proto_err}, 64'd0);
        check("rst_out_bits", {56'd0, out_bits}, 64'd0);
        check("rst_out_iters", {57'd0, out_iters}, 64'd0);
        check("rst_out_early", {63'd0, out_early}, 64'd0);
        rst_n = 1'b1;

        // Constant negative sums: convergence after iteration 3.
        do_start('0);
        send_iter(8'hFF, -1);
        send_iter(8'hFF, -1);
        send_iter(8'hFF, -1);
        expect_done("t1", 8'hFF, 3, 1'b1);
        consume("t1");

        // Alternating signs: never stable, stops at MAX_ITER with the last decisions.
        do_start('0);
        send_iter(8'hFF, -1);
        send_iter(8'h00, -1);
        send_iter(8'hFF, -1);
        send_iter(8'h00, -1);
        send_iter(8'hFF, -1);
        expect_done("t2", 8'hFF, 5, 1'b0);
        consume("t2");

        // Rails: even nodes saturate positive (bit 0), odd nodes sit on the negative rail (bit 1).
        do_start('0);
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < N; i++) begin
                send_node((i % 2 == 1) ? BIGN : BIGP, (i % 2 == 1) ? BIGN : BIGP, i == N - 1);
            end
        end
        expect_done("t3", 8'hAA, 3, 1'b1);
`ifdef BP_DEC_SOFT_OUT_EN
        check("t3_llr_node0", {44'd0, out_llr[0*W +: W]}, {44'd0, 20'h7FFFF});
        check("t3_llr_node1", {44'd0, out_llr[1*W +: W]}, {44'd0, 20'h80000});
`endif
        consume("t3");

        // Frozen low nibble forces those decisions to 0.
        do_start(8'h0F);
        send_iter(8'hFF, -1);
        send_iter(8'hFF, -1);
        send_iter(8'hFF, -1);
        expect_done("t4", 8'hF0, 3, 1'b1);
        consume("t4");

        // Stray in_last at node 5: one protocol error, the iteration still runs to node 7.
        do_start('0);
        p0 = perr_cnt;
        send_iter(8'h3C, 5);
        @(negedge clk);
        check("t5_proto_err_pulses", 64'(perr_cnt - p0), 64'd1);
        send_iter(8'h3C, -1);
        send_iter(8'h3C, -1);
        expect_done("t5", 8'h3C, 3, 1'b1);

        // Backpressure: result held while the sink stalls.
        snap_bits  = out_bits;
        snap_iters = out_iters;
        snap_early = out_early;
        hold_ok    = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_bits !== snap_bits ||
                out_iters !== snap_iters || out_early !== snap_early) hold_ok = 1'b0;
        end
        check("t6_hold_stable", {63'd0, hold_ok}, 64'd1);
        consume("t6");

        // Restart mid-COLLECT after one full iteration plus four nodes.
        do_start('0);
        send_iter(8'hAA, -1);
        for (int i = 0; i < 4; i++) send_node(P1, M3, 1'b0);
        do_start('0);
        send_iter(8'h55, -1);
        send_iter(8'h55, -1);
        send_iter(8'h55, -1);
        expect_done("t6_restart", 8'h55, 3, 1'b1);

        // Asynchronous reset while the result is presented.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("t6_arst_out_bits", {56'd0, out_bits}, 64'd0);
        check("t6_arst_out_iters", {57'd0, out_iters}, 64'd0);
        check("t6_arst_out_early", {63'd0, out_early}, 64'd0);
        check("t6_arst_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh frame after reset behaves normally.
        do_start('0);
        send_iter(8'h81, -1);
        send_iter(8'h81, -1);
        send_iter(8'h81, -1);
        expect_done("t7", 8'h81, 3, 1'b1);
        consume("t7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
